monster_random_move: RTL and testbench
======================================

MONSTER_RANDOM_MOVE -- requirements
Module: monster_random_move

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- INITIAL_X, 288, topLeftX after reset
- INITIAL_Y, 224, topLeftY after reset
- SPEED, 2, pixels moved per frame
- OBJECT_WIDTH_X, 32, monster width
- OBJECT_HEIGHT_Y, 32, monster height
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- CHANGE_FRAMES, 64, frames between forced direction re-picks
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, pixel clock
- resetN, in, 1, asynchronous active-low reset
- startOfFrame, in, 1, one-cycle frame pulse
- probe_hit, in, 1, current pixel lies on a probe line (upstream collision block)
- probe_dir, in, 2, probe direction of current pixel (upstream)
- wall_drawing_request, in, 1, current pixel is wall
- topLeftX, out, 11, monster X (unsigned)
- topLeftY, out, 11, monster Y (unsigned)
- random_move, out, 2, current direction, fed back to upstream
- moving, out, 1, last frame update moved the monster
- blocked_mask, out, 4, mask latched at last decision; bit index = direction code
REQ-003 The direction encoding SHALL be RIGHT=00, LEFT=01, DOWN=10, UP=11.

Function
REQ-004 The block SHALL have states COLLECT, DECIDE and MOVE, each held in a register.
REQ-005 In COLLECT, a cycle with probe_hit=1 and wall_drawing_request=1 SHALL set hit_mask[probe_dir]. Bits are sticky until MOVE.
REQ-006 A hit with wall_drawing_request=0 SHALL be ignored.
REQ-007 Hits in DECIDE or MOVE SHALL be discarded.
REQ-008 COLLECT SHALL go to DECIDE on startOfFrame=1. startOfFrame in DECIDE or MOVE SHALL be ignored.
REQ-009 DECIDE SHALL last one cycle and form blocked_eff = hit_mask OR edge bits. Edge bits:
- RIGHT if topLeftX+SPEED > SCREEN_W-OBJECT_WIDTH_X
- LEFT if topLeftX < SPEED
- DOWN if topLeftY+SPEED > SCREEN_H-OBJECT_HEIGHT_Y
- UP if topLeftY < SPEED
REQ-010 DECIDE SHALL latch blocked_eff into blocked_mask.
REQ-011 Re-pick rule in DECIDE: if blocked_eff[random_move]=1 or frame_cnt=CHANGE_FRAMES-1, the block SHALL choose the first unblocked code among c, c+1, c+2, c+3 (mod 4), where c=lfsr[1:0]. Otherwise random_move SHALL be kept.
REQ-012 If all four bits of blocked_eff are set, random_move SHALL be unchanged and the move SHALL be suppressed.
REQ-013 frame_cnt SHALL reset to 0 on any re-pick and otherwise increment in DECIDE. Width SHALL be $clog2(CHANGE_FRAMES).
REQ-014 The LFSR SHALL be 8 bits with taps x^8+x^6+x^5+x^4+1, shifting every clock in all states.
REQ-015 MOVE SHALL last one cycle and apply a SPEED step in the decided direction: X+/X-/Y+/Y- for RIGHT/LEFT/DOWN/UP.
REQ-016 MOVE SHALL set moving=1 if the step was applied and 0 if suppressed.
REQ-017 MOVE SHALL clear hit_mask and return to COLLECT.
REQ-018 Edge blocking SHALL keep topLeftX within [0, SCREEN_W-OBJECT_WIDTH_X] and topLeftY within [0, SCREEN_H-OBJECT_HEIGHT_Y]. No wrap-around or underflow is permitted.
REQ-019 Latency from startOfFrame sampled at edge N:
- random_move and blocked_mask valid after edge N+1
- topLeftX, topLeftY and moving valid after edge N+2
- back in COLLECT for cycle N+3

Reset
REQ-020 resetN=0 SHALL, asynchronously:
- set state to COLLECT
- set topLeftX=INITIAL_X, topLeftY=INITIAL_Y
- set random_move=RIGHT, moving=0, blocked_mask=0
- clear hit_mask and frame_cnt
- load lfsr=LFSR_SEED
REQ-021 Reset asserted mid-DECIDE or mid-MOVE SHALL abort the update with no partial position change.

Verification
REQ-022 Reset: pulse resetN low, then release -> topLeftX=288, topLeftY=224, random_move=00, moving=0, blocked_mask=0000.
REQ-023 No hits, one startOfFrame -> random_move=00; topLeftX=290 two edges after the decision edge; topLeftY=224; moving=1.
REQ-024 One cycle of probe_hit=1, probe_dir=00, wall_drawing_request=1, then startOfFrame -> blocked_mask=0001; random_move equals the reference-model pick from lfsr (never 00); position steps 2 in the new direction.
REQ-025 Hits on all four dirs, then startOfFrame -> blocked_mask=1111, random_move unchanged, position unchanged, moving=0.
REQ-026 Edge case, INITIAL_X=606, no hits:
- frame 1 -> topLeftX=608
- frame 2 -> RIGHT edge-blocked, random_move != 00, topLeftX never exceeds 608
REQ-027 Ignored inputs: probe_hit with wall_drawing_request=0 -> no mask bit set. With CHANGE_FRAMES=4, no hits -> forced re-pick at the 4th decision, then frame_cnt=0.

Source files
------------

// File: rtl/monster_random_move.sv
// Monster wanderer: collects wall hits on the upstream probe lines for one frame,
// then picks a direction from an LFSR if the current one is blocked or stale, and steps once.
module monster_random_move #(
    parameter int         INITIAL_X       = 288,
    parameter int         INITIAL_Y       = 224,
    parameter int         SPEED           = 2,
    parameter int         OBJECT_WIDTH_X  = 32,
    parameter int         OBJECT_HEIGHT_Y = 32,
    parameter int         SCREEN_W        = 640,
    parameter int         SCREEN_H        = 480,
    parameter int         CHANGE_FRAMES   = 64,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        probe_hit,
    input  logic [1:0]  probe_dir,
    input  logic        wall_drawing_request,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  random_move,
    output logic        moving,
    output logic [3:0]  blocked_mask
);

    localparam int         FCW     = (CHANGE_FRAMES > 1) ? $clog2(CHANGE_FRAMES) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(CHANGE_FRAMES - 1);
    localparam logic [11:0] MAX_X  = 12'(SCREEN_W - OBJECT_WIDTH_X);
    localparam logic [11:0] MAX_Y  = 12'(SCREEN_H - OBJECT_HEIGHT_Y);
    localparam logic [11:0] SPD    = 12'(SPEED);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic [1:0] {COLLECT, DECIDE, MOVE} state_t;

    state_t         state, state_next;
    logic [3:0]     hit_mask;
    logic [FCW-1:0] frame_cnt;
    logic [7:0]     lfsr;
    logic           suppress;

    logic [11:0]    x_ext, y_ext;
    logic [3:0]     edge_mask;
    logic [3:0]     blocked_eff;
    logic           all_blocked;
    logic           repick;
    logic [1:0]     pick_dir;
    logic [1:0]     pick_cand;
    logic           pick_found;
    logic           lfsr_fb;

    // Edge bits use one extra bit so X+SPEED cannot wrap before the compare.
    assign x_ext       = {1'b0, topLeftX};
    assign y_ext       = {1'b0, topLeftY};
    assign edge_mask   = {(y_ext < SPD), (y_ext + SPD > MAX_Y),
                          (x_ext < SPD), (x_ext + SPD > MAX_X)};
    assign blocked_eff = hit_mask | edge_mask;
    assign all_blocked = &blocked_eff;
    assign repick      = blocked_eff[random_move] || (frame_cnt == FC_LAST);
    assign lfsr_fb     = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Rotate from the random start code and take the first free direction.
    always_comb begin
        pick_dir   = random_move;
        pick_cand  = 2'b00;
        pick_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pick_cand = lfsr[1:0] + 2'(i);
            if (!pick_found && !blocked_eff[pick_cand]) begin
                pick_dir   = pick_cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (startOfFrame) state_next = DECIDE;
            DECIDE:  state_next = MOVE;
            MOVE:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= COLLECT;
            topLeftX     <= 11'(INITIAL_X);
            topLeftY     <= 11'(INITIAL_Y);
            random_move  <= DIR_RIGHT;
            moving       <= 1'b0;
            blocked_mask <= 4'b0000;
            hit_mask     <= 4'b0000;
            frame_cnt    <= '0;
            lfsr         <= LFSR_SEED;
            suppress     <= 1'b0;
        end else begin
            state <= state_next;
            lfsr  <= {lfsr[6:0], lfsr_fb};
            case (state)
                COLLECT: begin
                    if (probe_hit && wall_drawing_request)
                        hit_mask[probe_dir] <= 1'b1;
                end
                DECIDE: begin
                    blocked_mask <= blocked_eff;
                    suppress     <= all_blocked;
                    if (repick) begin
                        frame_cnt <= '0;
                        if (!all_blocked) random_move <= pick_dir;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                MOVE: begin
                    moving   <= !suppress;
                    hit_mask <= 4'b0000;
                    if (!suppress) begin
                        case (random_move)
                            DIR_RIGHT: topLeftX <= topLeftX + 11'(SPEED);
                            DIR_LEFT:  topLeftX <= topLeftX - 11'(SPEED);
                            DIR_DOWN:  topLeftY <= topLeftY + 11'(SPEED);
                            DIR_UP:    topLeftY <= topLeftY - 11'(SPEED);
                            default:   ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_monster_random_move.sv
// Bench for monster_random_move: three parameterisations driven in lockstep and checked
// against a per-frame arithmetic model of the collect/decide/move rules.
module tb_monster_random_move;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sof;
    logic        probe_hit;
    logic [1:0]  probe_dir;
    logic        wall;

    logic [10:0] x_o    [3];
    logic [10:0] y_o    [3];
    logic [1:0]  dir_o  [3];
    logic        mv_o   [3];
    logic [3:0]  mask_o [3];

    int n_checks = 0;
    int n_err    = 0;

    // clock / reset
    always #5 clk = ~clk;

    monster_random_move dut (
        .clk(clk), .resetN(rst_n), .startOfFrame(sof), .probe_hit(probe_hit),
        .probe_dir(probe_dir), .wall_drawing_request(wall),
        .topLeftX(x_o[0]), .topLeftY(y_o[0]), .random_move(dir_o[0]),
        .moving(mv_o[0]), .blocked_mask(mask_o[0]));

    monster_random_move #(.INITIAL_X(606)) dut_edge (
        .clk(clk), .resetN(rst_n), .startOfFrame(sof), .probe_hit(probe_hit),
        .probe_dir(probe_dir), .wall_drawing_request(wall),
        .topLeftX(x_o[1]), .topLeftY(y_o[1]), .random_move(dir_o[1]),
        .moving(mv_o[1]), .blocked_mask(mask_o[1]));

    monster_random_move #(.CHANGE_FRAMES(4)) dut_cf (
        .clk(clk), .resetN(rst_n), .startOfFrame(sof), .probe_hit(probe_hit),
        .probe_dir(probe_dir), .wall_drawing_request(wall),
        .topLeftX(x_o[2]), .topLeftY(y_o[2]), .random_move(dir_o[2]),
        .moving(mv_o[2]), .blocked_mask(mask_o[2]));

    // reference model: LFSR polynomial x^8+x^6+x^5+x^4+1 advanced once per clock
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= lfsr_next(m_lfsr);
    end

    // reference model: frame-level monster state per instance
    int init_x [3] = '{288, 606, 288};
    int cf     [3] = '{64, 64, 4};
    int ex [3], ey [3], edir [3], ecnt [3], emask [3], emv [3], esup [3];
    int exp_hit;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ex[i] = init_x[i]; ey[i] = 224; edir[i] = 0; ecnt[i] = 0;
            emask[i] = 0; emv[i] = 0; esup[i] = 0;
        end
        exp_hit = 0;
    endtask

    task automatic model_decide(input int l);
        int blk;
        for (int i = 0; i < 3; i++) begin
            blk = exp_hit;
            if (ex[i] + 2 > 640 - 32) blk |= 1;
            if (ex[i] < 2)            blk |= 2;
            if (ey[i] + 2 > 480 - 32) blk |= 4;
            if (ey[i] < 2)            blk |= 8;
            emask[i] = blk;
            esup[i]  = 0;
            if (((blk >> edir[i]) & 1) == 1 || ecnt[i] == cf[i] - 1) begin
                ecnt[i] = 0;
                if (blk == 15) begin
                    esup[i] = 1;
                end else begin
                    for (int k = 3; k >= 0; k--)
                        if (((blk >> ((l % 4 + k) % 4)) & 1) == 0) edir[i] = (l % 4 + k) % 4;
                end
            end else begin
                ecnt[i] = ecnt[i] + 1;
            end
        end
    endtask

    task automatic model_move();
        for (int i = 0; i < 3; i++) begin
            if (esup[i] == 0) begin
                case (edir[i])
                    0: ex[i] = ex[i] + 2;
                    1: ex[i] = ex[i] - 2;
                    2: ey[i] = ey[i] + 2;
                    default: ey[i] = ey[i] - 2;
                endcase
            end
            emv[i] = (esup[i] == 0) ? 1 : 0;
        end
        exp_hit = 0;
    endtask

    // scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_pos();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("x[%0d]", i), 32'(x_o[i]), ex[i]);
            check($sformatf("y[%0d]", i), 32'(y_o[i]), ey[i]);
            check($sformatf("moving[%0d]", i), 32'(mv_o[i]), emv[i]);
            check($sformatf("x_in_range[%0d]", i), 32'(x_o[i] <= 11'd608), 1);
            check($sformatf("y_in_range[%0d]", i), 32'(y_o[i] <= 11'd448), 1);
        end
        check("frame_cnt_cf", 32'(dut_cf.frame_cnt), ecnt[2]);
    endtask

    // driver tasks
    task automatic apply_hit(input int d, input logic w);
        @(negedge clk);
        probe_hit = 1'b1; probe_dir = 2'(d); wall = w;
        if (w) exp_hit |= (1 << d);
        @(negedge clk);
        probe_hit = 1'b0; wall = 1'b0;
    endtask

    task automatic do_frame(input bit junk);
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);                      // DECIDE cycle
        sof = 1'b0;
        model_decide(int'(m_lfsr));
        if (junk) begin
            probe_hit = 1'b1; wall = 1'b1; probe_dir = 2'($urandom_range(0, 3));
        end
        sof = junk ? 1'b1 : 1'b0;            // frame pulses outside COLLECT must be ignored
        @(negedge clk);                      // MOVE cycle
        sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dir[%0d]", i), 32'(dir_o[i]), edir[i]);
            check($sformatf("mask[%0d]", i), 32'(mask_o[i]), emask[i]);
        end
        @(negedge clk);                      // back in COLLECT
        probe_hit = 1'b0; wall = 1'b0;
        model_move();
        check_outputs_pos();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic reset_mid(input int phase);
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        if (phase == 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort%0d_x[%0d]", phase, i), 32'(x_o[i]), ex[i]);
            check($sformatf("abort%0d_y[%0d]", phase, i), 32'(y_o[i]), ey[i]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_pos();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sof = 1'b0; probe_hit = 1'b0; probe_dir = 2'b00; wall = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        // reset state
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_dir[%0d]", i), 32'(dir_o[i]), 0);
            check($sformatf("rst_mask[%0d]", i), 32'(mask_o[i]), 0);
        end
        check_outputs_pos();
        check("rst_x0", 32'(x_o[0]), 288);
        check("rst_y0", 32'(y_o[0]), 224);

        // frame 1: no hits, plain step right
        do_frame(1'b0);
        check("f1_x0", 32'(x_o[0]), 290);
        check("f1_y0", 32'(y_o[0]), 224);
        check("f1_moving0", 32'(mv_o[0]), 1);
        check("f1_x_edge", 32'(x_o[1]), 608);

        // frame 2: wall hit on RIGHT probe
        apply_hit(0, 1'b1);
        do_frame(1'b0);
        check("f2_mask0", 32'(mask_o[0]), 1);
        check("f2_dir0_not_right", 32'(dir_o[0] != 2'b00), 1);
        check("f2_edge_dir_not_right", 32'(dir_o[1] != 2'b00), 1);
        check("f2_edge_x_le608", 32'(x_o[1] <= 11'd608), 1);

        // frame 3: all four directions hit
        for (int d = 0; d < 4; d++) apply_hit(d, 1'b1);
        do_frame(1'b1);
        check("f3_mask0", 32'(mask_o[0]), 15);
        check("f3_moving0", 32'(mv_o[0]), 0);

        // frame 4: hit without wall pixel is ignored
        apply_hit(1, 1'b0);
        apply_hit(3, 1'b0);
        do_frame(1'b1);
        check("f4_mask0", 32'(mask_o[0]), 0);

        // forced re-pick after CHANGE_FRAMES decisions
        do_reset();
        for (int f = 1; f <= 4; f++) begin
            do_frame(1'b0);
            if (f == 3) check("cf_cnt_before_repick", 32'(dut_cf.frame_cnt), 3);
            if (f == 4) check("cf_cnt_after_repick", 32'(dut_cf.frame_cnt), 0);
        end

        // randomized frames
        for (int f = 0; f < 60; f++) begin
            int nh;
            nh = $urandom_range(0, 3);
            for (int h = 0; h < nh; h++)
                apply_hit($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            do_frame(1'($urandom_range(0, 1)));
        end

        // reset during DECIDE and during MOVE aborts the update
        reset_mid(1);
        do_frame(1'b0);
        reset_mid(2);
        do_frame(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
